// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   memSize_t    : access-size encoding carried down the pipeline (reserved code acts as word)
//   exMem_t      : EX/MEM pipeline register contents
//   memWb_t      : MEM/WB pipeline register contents
//   isMisaligned : alignment check for an access size and byte lane
//   byteEnable   : per-lane write enables for an access size and byte lane
//   storeLanes   : replicates store data across all lanes
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11
  } memSize_t;

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic [4:0]  regDest;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    memSize_t    memSize;
    logic        memSigned;
    logic        memToReg;
  } exMem_t;

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] readData;
    logic [4:0]  regDest;
    logic        regWrite;
    logic        memToReg;
    logic        misalign;
  } memWb_t;

  function automatic logic isMisaligned(input memSize_t size, input logic [1:0] lane);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return lane[0];
      default:  return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byteEnable(input memSize_t size, input logic [1:0] lane);
    case (size)
      MEM_BYTE: return 4'b0001 << lane;
      MEM_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] storeLanes(input memSize_t size, input logic [31:0] data);
    case (size)
      MEM_BYTE: return {4{data[7:0]}};
      MEM_HALF: return {2{data[15:0]}};
      default:  return data;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory with per-byte write enables.
//   Clock     : write clock (rising edge)
//   ByteEn    : lane write enables, lane 0 = bits 7:0
//   WriteData : lane-replicated store data
//   Index     : word index, shared by read and write
//   ReadData  : asynchronous read of the addressed word (pre-write value during a write cycle)
module data_memory #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clock,
  input  logic [3:0]        ByteEn,
  input  logic [31:0]       WriteData,
  input  logic [ADDR_W-1:0] Index,
  output logic [31:0]       ReadData
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (ByteEn[i]) mem[Index][8*i +: 8] <= WriteData[8*i +: 8];
    end
  end

  assign ReadData = mem[Index];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data memory access, load extension, MEM/WB register.
//   Clock, Reset (sync, active-low), Stall (hold EX/MEM, bubble MEM/WB), Flush (bubble EX/MEM)
//   EX_*          : results and control from the EX stage
//   EXMEM_*, FWFromMEM, MEM_ReadData : forwarding operands back to EX
//   WB_*, MisalignFault              : MEM/WB register contents for write-back
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] EX_ALUResult,
  input  logic [31:0] EX_StoreData,
  input  logic [4:0]  EX_RegDest,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic [1:0]  EX_MemSize,
  input  logic        EX_MemSigned,
  input  logic        EX_MemToReg,
  output logic [4:0]  EXMEM_RegDest,
  output logic        EXMEM_WriteEnable,
  output logic [31:0] FWFromMEM,
  output logic [31:0] MEM_ReadData,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_ReadData,
  output logic [4:0]  WB_RegDest,
  output logic        WB_RegWrite,
  output logic        WB_MemToReg,
  output logic        MisalignFault
);

  exMem_t      exMem;
  memWb_t      memWb;
  logic [1:0]  lane;
  logic        misaligned;
  logic        accessFault;
  logic [3:0]  byteEn;
  logic [31:0] rawWord;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadData;

  always_ff @(posedge Clock) begin
    if (!Reset || Flush) begin
      exMem <= '0;
    end else if (!Stall) begin
      exMem.aluResult <= EX_ALUResult;
      exMem.storeData <= EX_StoreData;
      exMem.regDest   <= EX_RegDest;
      exMem.regWrite  <= EX_RegWrite;
      exMem.memRead   <= EX_MemRead;
      exMem.memWrite  <= EX_MemWrite;
      exMem.memSize   <= memSize_t'(EX_MemSize);
      exMem.memSigned <= EX_MemSigned;
      exMem.memToReg  <= EX_MemToReg;
    end
  end

  assign lane        = exMem.aluResult[1:0];
  assign misaligned  = isMisaligned(exMem.memSize, lane);
  assign accessFault = misaligned && (exMem.memRead || exMem.memWrite);

  // Gating the write with Stall makes a held store commit exactly once, on the edge Stall drops.
  assign byteEn = (exMem.memWrite && !misaligned && !Stall && Reset)
                  ? byteEnable(exMem.memSize, lane) : '0;

  data_memory #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dataMemory (
    .Clock     (Clock),
    .ByteEn    (byteEn),
    .WriteData (storeLanes(exMem.memSize, exMem.storeData)),
    .Index     (exMem.aluResult[ADDR_W+1:2]),
    .ReadData  (rawWord)
  );

  always_comb begin
    laneByte = rawWord[{lane, 3'b000} +: 8];
    laneHalf = lane[1] ? rawWord[31:16] : rawWord[15:0];
    loadData = '0;
    if (exMem.memRead && !misaligned) begin
      case (exMem.memSize)
        MEM_BYTE: loadData = {{24{exMem.memSigned & laneByte[7]}}, laneByte};
        MEM_HALF: loadData = {{16{exMem.memSigned & laneHalf[15]}}, laneHalf};
        default:  loadData = rawWord;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset || Stall) begin
      memWb <= '0;
    end else begin
      memWb.aluResult <= exMem.aluResult;
      memWb.readData  <= loadData;
      memWb.regDest   <= exMem.regDest;
      memWb.regWrite  <= exMem.regWrite;
      memWb.memToReg  <= exMem.memToReg;
      memWb.misalign  <= accessFault;
    end
  end

  assign EXMEM_RegDest     = exMem.regDest;
  assign EXMEM_WriteEnable = exMem.regWrite;
  assign FWFromMEM         = exMem.aluResult;
  assign MEM_ReadData      = loadData;
  assign WB_ALUResult      = memWb.aluResult;
  assign WB_ReadData       = memWb.readData;
  assign WB_RegDest        = memWb.regDest;
  assign WB_RegWrite       = memWb.regWrite;
  assign WB_MemToReg       = memWb.memToReg;
  assign MisalignFault     = memWb.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a byte-array memory model.
module tb_mem_stage;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic        Clock, Reset, Stall, Flush;
  logic [31:0] EX_ALUResult, EX_StoreData;
  logic [4:0]  EX_RegDest;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemSigned, EX_MemToReg;
  logic [1:0]  EX_MemSize;
  logic [4:0]  EXMEM_RegDest, WB_RegDest;
  logic        EXMEM_WriteEnable, WB_RegWrite, WB_MemToReg, MisalignFault;
  logic [31:0] FWFromMEM, MEM_ReadData, WB_ALUResult, WB_ReadData;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mb [DEPTH*4];

  mem_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .EX_ALUResult(EX_ALUResult), .EX_StoreData(EX_StoreData), .EX_RegDest(EX_RegDest),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemSize(EX_MemSize), .EX_MemSigned(EX_MemSigned), .EX_MemToReg(EX_MemToReg),
    .EXMEM_RegDest(EXMEM_RegDest), .EXMEM_WriteEnable(EXMEM_WriteEnable),
    .FWFromMEM(FWFromMEM), .MEM_ReadData(MEM_ReadData),
    .WB_ALUResult(WB_ALUResult), .WB_ReadData(WB_ReadData), .WB_RegDest(WB_RegDest),
    .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg), .MisalignFault(MisalignFault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [1:0] sz,
                       input logic sg, input logic m2r);
    EX_ALUResult = a;  EX_StoreData = d; EX_RegDest = rd; EX_RegWrite = rw;
    EX_MemRead   = mr; EX_MemWrite  = mw; EX_MemSize = sz; EX_MemSigned = sg;
    EX_MemToReg  = m2r;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---- reference model: byte-addressed memory, address arithmetic from the access rules ----
  function automatic int unsigned mdlBase(input logic [31:0] a);
    return ((a / 4) % DEPTH) * 4;
  endfunction

  function automatic logic mdlMis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd2) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] mdlLoad(input logic [31:0] a, input logic [1:0] sz,
                                          input logic sg, input logic rd);
    int unsigned b, l;
    logic [31:0] v;
    if (!rd || mdlMis(sz, a)) return 0;
    b = mdlBase(a);
    l = a % 4;
    if (sz == 2'd2) begin
      v = 32'(mb[b+l]);
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = 32'(mb[b+l]) + 256 * 32'(mb[b+l+1]);
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = 32'(mb[b]) + 256 * 32'(mb[b+1]) + 65536 * 32'(mb[b+2]) + 16777216 * 32'(mb[b+3]);
    end
    return v;
  endfunction

  task automatic mdlStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int unsigned b, l;
    if (mdlMis(sz, a)) return;
    b = mdlBase(a);
    l = a % 4;
    if (sz == 2'd2) begin
      mb[b+l] = 8'(d % 256);
    end else if (sz == 2'd1) begin
      mb[b+l]   = 8'(d % 256);
      mb[b+l+1] = 8'((d / 256) % 256);
    end else begin
      for (int unsigned k = 0; k < 4; k++) mb[b+k] = 8'((d >> (8*k)) % 256);
    end
  endtask

  // One isolated transaction: check EX/MEM view, MEM/WB view, then the following bubble.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] sz, input logic sg, input logic m2r);
    logic [31:0] expLoad;
    logic        expMis;
    drive(a, d, rd, rw, mr, mw, sz, sg, m2r);
    tick();
    idle();
    expLoad = mdlLoad(a, sz, sg, mr);
    expMis  = mdlMis(sz, a) && (mr || mw);
    chk({tag, ".exRd"},   EXMEM_RegDest, rd);
    chk({tag, ".exWe"},   EXMEM_WriteEnable, rw);
    chk({tag, ".fw"},     FWFromMEM, a);
    chk({tag, ".memRd"},  MEM_ReadData, expLoad);
    if (mw) mdlStore(a, sz, d);
    tick();
    chk({tag, ".wbAlu"},  WB_ALUResult, a);
    chk({tag, ".wbRd"},   WB_ReadData, expLoad);
    chk({tag, ".wbDst"},  WB_RegDest, rd);
    chk({tag, ".wbWe"},   WB_RegWrite, rw);
    chk({tag, ".wbM2r"},  WB_MemToReg, m2r);
    chk({tag, ".fault"},  MisalignFault, expMis);
    tick();
    chk({tag, ".fault1"}, MisalignFault, 0);
    chk({tag, ".wbWe1"},  WB_RegWrite, 0);
  endtask

  initial begin
    logic [31:0] pre, a, d;
    logic [1:0]  sz;

    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
    idle();

    // 1. reset: all outputs zero
    tick(); tick();
    chk("rst.exRd", EXMEM_RegDest, 0);
    chk("rst.exWe", EXMEM_WriteEnable, 0);
    chk("rst.fw", FWFromMEM, 0);
    chk("rst.memRd", MEM_ReadData, 0);
    chk("rst.wbAlu", WB_ALUResult, 0);
    chk("rst.wbRd", WB_ReadData, 0);
    chk("rst.wbDst", WB_RegDest, 0);
    chk("rst.wbWe", WB_RegWrite, 0);
    chk("rst.wbM2r", WB_MemToReg, 0);
    chk("rst.fault", MisalignFault, 0);
    Reset = 1'b1;

    // give words 0..31 known contents
    for (int unsigned i = 0; i < 32; i++) issue("init", 32'(i*4), $urandom, 0, 0, 0, 1, 2'd0, 0, 0);

    // store presented during reset must not reach memory
    issue("preRst", 32'h20, 32'hCAFEF00D, 0, 0, 0, 1, 2'd0, 0, 0);
    Reset = 1'b0;
    drive(32'h20, 32'h12345678, 0, 0, 0, 1, 2'd0, 0, 0);
    tick(); tick();
    idle();
    Reset = 1'b1;
    tick();
    issue("rstSt", 32'h20, 0, 3, 1, 1, 0, 2'd0, 0, 1);

    // 2. store then back-to-back word load of the same address
    drive(32'h10, 32'hDEADBEEF, 0, 0, 0, 1, 2'd0, 0, 0);
    tick();
    drive(32'h10, 0, 5, 1, 1, 0, 2'd0, 0, 1);
    tick();
    idle();
    chk("b2b.memRd", MEM_ReadData, 32'hDEADBEEF);
    chk("b2b.stWe", WB_RegWrite, 0);
    mdlStore(32'h10, 2'd0, 32'hDEADBEEF);
    tick();
    chk("b2b.wbRd", WB_ReadData, 32'hDEADBEEF);
    chk("b2b.wbDst", WB_RegDest, 5);
    tick();

    // 3. byte loads and half store
    issue("w80", 32'h10, 32'h80FF7F01, 0, 0, 0, 1, 2'd0, 0, 0);
    issue("lbS", 32'h13, 0, 4, 1, 1, 0, 2'd2, 1, 1);
    issue("lbU", 32'h13, 0, 4, 1, 1, 0, 2'd2, 0, 1);
    issue("sh12", 32'h12, 32'h0000ABCD, 0, 0, 0, 1, 2'd1, 0, 0);
    issue("lw10", 32'h10, 0, 6, 1, 1, 0, 2'd0, 0, 1);
    chk("sh12.word", mdlLoad(32'h10, 2'd0, 0, 1), 32'hABCD7F01);

    // 4. misaligned accesses
    issue("swMis", 32'h06, 32'h11223344, 0, 0, 0, 1, 2'd0, 0, 0);
    issue("lw04", 32'h04, 0, 1, 1, 1, 0, 2'd0, 0, 1);
    issue("lhMis", 32'h01, 0, 2, 1, 1, 0, 2'd1, 1, 1);

    // 5. stalled store+load: memory unchanged until the stall drops
    pre = mdlLoad(32'h40, 2'd0, 0, 1);
    drive(32'h40, 32'h55AA55AA, 7, 1, 1, 1, 2'd0, 0, 1);
    tick();
    idle();
    Stall = 1'b1;
    chk("stall.pre", MEM_ReadData, pre);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("stall.wbWe", WB_RegWrite, 0);
      chk("stall.hold", MEM_ReadData, pre);
      chk("stall.exRd", EXMEM_RegDest, 7);
    end
    Stall = 1'b0;
    tick();
    chk("stall.wbWe1", WB_RegWrite, 1);
    chk("stall.wbRd", WB_ReadData, pre);
    mdlStore(32'h40, 2'd0, 32'h55AA55AA);
    tick();
    issue("stall.chk", 32'h40, 0, 8, 1, 1, 0, 2'd0, 0, 1);

    // Flush and Stall together clear EX/MEM
    drive(32'h1234, 0, 9, 1, 0, 0, 2'd0, 0, 0);
    tick();
    idle();
    chk("fl.exRd0", EXMEM_RegDest, 9);
    Flush = 1'b1; Stall = 1'b1;
    tick();
    Flush = 1'b0; Stall = 1'b0;
    chk("fl.exRd", EXMEM_RegDest, 0);
    chk("fl.exWe", EXMEM_WriteEnable, 0);
    chk("fl.fw", FWFromMEM, 0);
    tick();
    chk("fl.wbWe", WB_RegWrite, 0);
    chk("fl.wbAlu", WB_ALUResult, 0);

    // 6. address wrap-around
    issue("wrap0", 32'h0, 32'h0BADCAFE, 0, 0, 0, 1, 2'd0, 0, 0);
    issue("wrap1", 32'h1000, 32'h600DF00D, 0, 0, 0, 1, 2'd0, 0, 0);
    issue("wrapLd", 32'h0, 0, 10, 1, 1, 0, 2'd0, 0, 1);
    chk("wrap.word", mdlLoad(32'h0, 2'd0, 0, 1), 32'h600DF00D);

    // randomized transactions within the initialised region (upper bits exercise wrap)
    for (int unsigned i = 0; i < 60; i++) begin
      a  = $urandom & 32'hFFFFF07F;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a = a & ~32'h1;
        else if (sz != 2'd2) a = a & ~32'h3;
      end
      d = $urandom;
      issue("rand", a, d, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
